// File: rtl/aespim_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aespim_pkg
// Brief    : Opcodes, FSM states, Rcon table and GF(2^8) helpers for the
//            AES PIM column-state engine.
// Revision : 1.0
// ============================================================================
package aespim_pkg;

   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,
      OP_LD   = 4'd1,
      OP_ST   = 4'd2,
      OP_KEXI = 4'd3,
      OP_KEXS = 4'd4,
      OP_KEX  = 4'd5,
      OP_ENCI = 4'd6,
      OP_ENCF = 4'd7,
      OP_DECM = 4'd8,
      OP_RCLR = 4'd9
   } eng_op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SUB    = 2'd1,
      ST_COMMIT = 2'd2,
      ST_RSP    = 2'd3
   } eng_state_e;

   localparam logic [9:0][7:0] RCON = {8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                       8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

   function automatic logic [7:0] aespim_rcon(input logic [3:0] idx);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 10; i++) begin
         if (idx == 4'(i)) r = RCON[i];
      end
      return r;
   endfunction

   function automatic logic aespim_op_uses_sbox(input eng_op_e op);
      return (op == OP_KEXI) || (op == OP_KEXS) || (op == OP_ENCF) || (op == OP_DECM);
   endfunction

   function automatic logic [7:0] aespim_gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // a^254 == a^-1 in GF(2^8), and maps 0 to 0 as the S-box requires
   function automatic logic [7:0] aespim_gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = a;
      acc = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq  = aespim_gf_mul(sq, sq);
         acc = aespim_gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [31:0] aespim_inv_mixcolumn(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {aespim_gf_mul(a0, 8'h0e) ^ aespim_gf_mul(a1, 8'h0b) ^ aespim_gf_mul(a2, 8'h0d) ^ aespim_gf_mul(a3, 8'h09),
              aespim_gf_mul(a0, 8'h09) ^ aespim_gf_mul(a1, 8'h0e) ^ aespim_gf_mul(a2, 8'h0b) ^ aespim_gf_mul(a3, 8'h0d),
              aespim_gf_mul(a0, 8'h0d) ^ aespim_gf_mul(a1, 8'h09) ^ aespim_gf_mul(a2, 8'h0e) ^ aespim_gf_mul(a3, 8'h0b),
              aespim_gf_mul(a0, 8'h0b) ^ aespim_gf_mul(a1, 8'h0d) ^ aespim_gf_mul(a2, 8'h09) ^ aespim_gf_mul(a3, 8'h0e)};
   endfunction

endpackage
`default_nettype wire

// File: rtl/aespim_sub_word.sv
`default_nettype none
// ============================================================================
// Module   : aespim_bSbox / aespim_sub_word
// Brief    : Forward/inverse AES S-box and a time-multiplexed SubWord unit
//            that fills a shadow register NUM_SBOX bytes per cycle.
// Revision : 1.0
// ============================================================================
module aespim_bSbox
   import aespim_pkg::*;
(
   input  logic [7:0] in_i,
   input  logic       inv_i,
   output logic [7:0] out_o
);
   logic [7:0] w_pre;
   logic [7:0] w_inv;

   always_comb begin
      // Inverse affine first for ISW; forward affine last for SW
      w_pre = inv_i ? ({in_i[6:0], in_i[7]} ^ {in_i[4:0], in_i[7:5]} ^ {in_i[1:0], in_i[7:2]} ^ 8'h05)
                    : in_i;
      w_inv = aespim_gf_inv(w_pre);
      out_o = inv_i ? w_inv
                    : (w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]} ^
                       {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63);
   end
endmodule

module aespim_sub_word #(
   parameter int NUM_SBOX = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        en_i,
   input  logic        clr_i,
   input  logic        inv_i,
   input  logic [31:0] word_i,
   output logic        done_o,
   output logic [31:0] word_o
);
   localparam int SW_CYC = 4 / NUM_SBOX;

   logic [1:0]                cnt_q, cnt_d;
   logic [31:0]               shadow_q, shadow_d;
   logic [NUM_SBOX-1:0][1:0]  w_lane;
   logic [NUM_SBOX-1:0][7:0]  w_sb_in;
   logic [NUM_SBOX-1:0][7:0]  w_sb_out;
   logic                      w_last;

   generate
      for (genvar j = 0; j < NUM_SBOX; j++) begin : g_sbox
         aespim_bSbox u_sbox (
            .in_i  (w_sb_in[j]),
            .inv_i (inv_i),
            .out_o (w_sb_out[j])
         );
      end
   endgenerate

   always_comb begin
      w_last = (cnt_q == 2'(SW_CYC - 1));
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      for (int j = 0; j < NUM_SBOX; j++) begin
         w_lane[j]  = 2'(int'(cnt_q) * NUM_SBOX + j);
         w_sb_in[j] = word_i[8*w_lane[j] +: 8];
      end
      if (clr_i) begin
         shadow_d = '0;
         cnt_d    = '0;
      end else if (en_i) begin
         for (int j = 0; j < NUM_SBOX; j++) shadow_d[8*w_lane[j] +: 8] = w_sb_out[j];
         cnt_d = w_last ? 2'd0 : cnt_q + 2'd1;
      end else begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q    <= '0;
         shadow_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
      end
   end

   assign done_o = en_i && w_last && !clr_i;
   assign word_o = shadow_q;
endmodule
`default_nettype wire

// File: rtl/aespim_state_engine.sv
`default_nettype none
// ============================================================================
// Module   : aespim_state_engine
// Brief    : AES column-queue engine (round / key-schedule word ops) with a
//            valid/ready request-response handshake. Optional zeroize port
//            enabled by AESPIM_ZEROIZE_EN.
// Revision : 1.0
// ============================================================================
module aespim_state_engine
   import aespim_pkg::*;
#(
   parameter int NUM_COLS = 4,
   parameter int NUM_SBOX = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  eng_op_e     req_op_i,
   input  logic [1:0]  req_sr_i,
   input  logic [31:0] req_data_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_data_o,
   output logic        busy_o,
   output logic [3:0]  rcon_idx_o
`ifdef AESPIM_ZEROIZE_EN
   ,
   input  logic        zeroize_i
`endif
);
   eng_state_e                 state_q, state_d;
   eng_op_e                    op_q, op_d;
   logic [1:0]                 sr_q, sr_d;
   logic [31:0]                data_q, data_d;
   logic [NUM_COLS-1:0][31:0]  queue_q, queue_d;
   logic [3:0]                 rcon_idx_q, rcon_idx_d;
   logic                       rsp_valid_q, rsp_valid_d;
   logic [31:0]                rsp_data_q, rsp_data_d;

   logic                       w_zeroize;
   logic [31:0]                w_head, w_tail;
   logic [31:0]                w_sw_in, w_sw_out;
   logic                       w_sw_done;
   logic [31:0]                w_word;
   logic                       w_push;
   logic [1:0]                 w_sr;
   logic [NUM_COLS-1:0][31:0]  w_shifted, w_pushed;

`ifdef AESPIM_ZEROIZE_EN
   assign w_zeroize = zeroize_i;
`else
   assign w_zeroize = 1'b0;
`endif

   assign w_head = queue_q[0];
   assign w_tail = queue_q[NUM_COLS-1];

   always_comb begin
      case (op_q)
         OP_KEXI: w_sw_in = {w_tail[23:0], w_tail[31:24]};
         OP_KEXS: w_sw_in = w_tail;
         default: w_sw_in = w_head;
      endcase
   end

   aespim_sub_word #(.NUM_SBOX(NUM_SBOX)) u_sub_word (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (state_q == ST_SUB),
      .clr_i  (w_zeroize),
      .inv_i  (op_q == OP_DECM),
      .word_i (w_sw_in),
      .done_o (w_sw_done),
      .word_o (w_sw_out)
   );

   always_comb begin
      w_word = 32'h0;
      w_push = 1'b1;
      case (op_q)
         OP_LD:   w_word = data_q;
         OP_ST:   w_word = w_head;
         OP_KEXI: w_word = w_head ^ w_sw_out ^ {aespim_rcon(rcon_idx_q), 24'h0};
         OP_KEXS: w_word = w_head ^ w_sw_out;
         OP_KEX:  w_word = w_head ^ w_tail;
         OP_ENCI: w_word = data_q ^ w_head;
         OP_ENCF: w_word = data_q ^ w_sw_out;
         OP_DECM: w_word = data_q ^ aespim_inv_mixcolumn(w_sw_out);
         default: w_push = 1'b0;
      endcase
      w_sr = (op_q == OP_ST) ? 2'd0 : sr_q;
   end

   // ShiftRows push: lane b lands S-1-b... columns early and freezes the columns above it
   always_comb begin
      w_shifted[NUM_COLS-1] = w_word;
      for (int k = 0; k < NUM_COLS-1; k++) w_shifted[k] = queue_q[k+1];
      w_pushed = w_shifted;
      for (int b = 0; b < 4; b++) begin
         if (b < int'(w_sr)) begin
            for (int k = 0; k < NUM_COLS; k++) begin
               if (k == NUM_COLS-2-b)
                  w_pushed[k][8*b +: 8] = w_word[8*b +: 8];
               else if (k > NUM_COLS-2-b)
                  w_pushed[k][8*b +: 8] = queue_q[k][8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      sr_d        = sr_q;
      data_d      = data_q;
      queue_d     = queue_q;
      rcon_idx_d  = rcon_idx_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      if (w_zeroize) begin
         state_d     = ST_IDLE;
         op_d        = OP_NOP;
         sr_d        = '0;
         data_d      = '0;
         queue_d     = '0;
         rcon_idx_d  = '0;
         rsp_valid_d = 1'b0;
         rsp_data_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid_i) begin
                  op_d    = req_op_i;
                  sr_d    = req_sr_i;
                  data_d  = req_data_i;
                  state_d = aespim_op_uses_sbox(req_op_i) ? ST_SUB : ST_COMMIT;
               end
            end
            ST_SUB: begin
               if (w_sw_done) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
               if (w_push) queue_d = w_pushed;
               if (op_q == OP_KEXI) rcon_idx_d = (rcon_idx_q == 4'd9) ? 4'd0 : rcon_idx_q + 4'd1;
               if (op_q == OP_RCLR) rcon_idx_d = 4'd0;
               rsp_valid_d = 1'b1;
               rsp_data_d  = w_word;
               state_d     = ST_RSP;
            end
            default: begin
               if (rsp_ready_i) begin
                  rsp_valid_d = 1'b0;
                  rsp_data_d  = '0;
                  state_d     = ST_IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_NOP;
         sr_q        <= '0;
         data_q      <= '0;
         queue_q     <= '0;
         rcon_idx_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         sr_q        <= sr_d;
         data_q      <= data_d;
         queue_q     <= queue_d;
         rcon_idx_q  <= rcon_idx_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign req_ready_o = (state_q == ST_IDLE);
   assign busy_o      = (state_q != ST_IDLE);
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign rcon_idx_o  = rcon_idx_q;
endmodule
`default_nettype wire
